// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
// Bundles the requester-side (icache "i_", dcache "d_") and DDR2
// controller-side FIFO signals shared by cache_mem_arbiter.
//   slave  : arbiter view (requests/controller status in, handshakes out)
//   master : environment view (drives requests and controller status)
// Parameters: ADDR_W line address width, DATA_W FIFO beat width.
interface cache_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 31,
   parameter int unsigned DATA_W = 128
);
   localparam int unsigned MASK_W = DATA_W / 8;

   // icache requester
   logic              i_req_valid;
   logic              i_req_we;
   logic [ADDR_W-1:0] i_req_addr;
   logic              i_req_ready;
   logic [DATA_W-1:0] i_wdata;
   logic [MASK_W-1:0] i_wmask;
   logic              i_wdata_ready;
   logic [DATA_W-1:0] i_rdata;
   logic              i_rdata_valid;

   // dcache requester
   logic              d_req_valid;
   logic              d_req_we;
   logic [ADDR_W-1:0] d_req_addr;
   logic              d_req_ready;
   logic [DATA_W-1:0] d_wdata;
   logic [MASK_W-1:0] d_wmask;
   logic              d_wdata_ready;
   logic [DATA_W-1:0] d_rdata;
   logic              d_rdata_valid;

   // controller FIFOs
   logic [2:0]        af_cmd;
   logic [ADDR_W-1:0] af_addr_din;
   logic              af_wr_en;
   logic              af_full;
   logic [DATA_W-1:0] wdf_din;
   logic [MASK_W-1:0] wdf_mask_din;
   logic              wdf_wr_en;
   logic              wdf_full;
   logic [DATA_W-1:0] rdf_dout;
   logic              rdf_valid;

   // status
   logic              busy;
   logic              owner;

   modport slave (
      input  i_req_valid, i_req_we, i_req_addr, i_wdata, i_wmask,
      input  d_req_valid, d_req_we, d_req_addr, d_wdata, d_wmask,
      input  af_full, wdf_full, rdf_dout, rdf_valid,
      output i_req_ready, i_wdata_ready, i_rdata, i_rdata_valid,
      output d_req_ready, d_wdata_ready, d_rdata, d_rdata_valid,
      output af_cmd, af_addr_din, af_wr_en,
      output wdf_din, wdf_mask_din, wdf_wr_en,
      output busy, owner
   );

   modport master (
      output i_req_valid, i_req_we, i_req_addr, i_wdata, i_wmask,
      output d_req_valid, d_req_we, d_req_addr, d_wdata, d_wmask,
      output af_full, wdf_full, rdf_dout, rdf_valid,
      input  i_req_ready, i_wdata_ready, i_rdata, i_rdata_valid,
      input  d_req_ready, d_wdata_ready, d_rdata, d_rdata_valid,
      input  af_cmd, af_addr_din, af_wr_en,
      input  wdf_din, wdf_mask_din, wdf_wr_en,
      input  busy, owner
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one DDR2 controller command/write-data/read-data FIFO set between
// the icache and dcache miss paths, one cache line transaction at a time.
// Writes push all BEATS data beats before the command; reads push the
// command and then forward BEATS returning beats to the owning cache.
// Ports:
//   clk  : CPU clock, posedge
//   rst  : synchronous active-low reset
//   bus  : cache_mem_arbiter_if.slave (requesters, controller FIFOs, status)
// Parameters: ADDR_W, DATA_W, BEATS (power of two, 2..8).
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise
// dcache has fixed priority.
module cache_mem_arbiter #(
   parameter int unsigned ADDR_W = 31,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned BEATS  = 2
) (
   input  logic               clk,
   input  logic               rst,
   cache_mem_arbiter_if.slave bus
);
   localparam int unsigned     CNT_W     = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      CMD   = 2'd2,
      RDATA = 2'd3
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
`ifdef ARB_RR_EN
   logic              last_d_q;   // 1 = dcache granted last
`endif

   logic              any_req_c;
   logic              win_c;      // 1 = dcache wins
   logic              sel_we_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic              grant_c;
   logic              wdf_push_c;
   logic              af_push_c;
   logic              rd_beat_c;

   // Winner selection among pending requesters
   always_comb begin
      any_req_c = bus.i_req_valid | bus.d_req_valid;
`ifdef ARB_RR_EN
      // on contention the requester not granted last wins
      if (bus.i_req_valid && bus.d_req_valid) begin
         win_c = ~last_d_q;
      end else begin
         win_c = bus.d_req_valid;
      end
`else
      win_c = bus.d_req_valid;
`endif
      sel_we_c   = win_c ? bus.d_req_we   : bus.i_req_we;
      sel_addr_c = win_c ? bus.d_req_addr : bus.i_req_addr;
   end

   // Per-state handshakes; all forced low while in reset
   always_comb begin
      grant_c    = 1'b0;
      wdf_push_c = 1'b0;
      af_push_c  = 1'b0;
      rd_beat_c  = 1'b0;
      if (rst) begin
         case (state_q)
            IDLE:    grant_c    = any_req_c;
            WDATA:   wdf_push_c = ~bus.wdf_full;
            CMD:     af_push_c  = ~bus.af_full;
            RDATA:   rd_beat_c  = bus.rdf_valid;
            default: ;
         endcase
      end
   end

   // Sequencer: state, beat counter and latched transaction fields
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
`ifdef ARB_RR_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_c) begin
                  owner_q  <= win_c;
                  we_q     <= sel_we_c;
                  addr_q   <= sel_addr_c;
                  cnt_q    <= '0;
                  state_q  <= sel_we_c ? WDATA : CMD;
`ifdef ARB_RR_EN
                  last_d_q <= win_c;
`endif
               end
            end
            WDATA: begin
               if (wdf_push_c) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_BEAT) state_q <= CMD;
               end
            end
            CMD: begin
               // counter has wrapped to zero here for writes and was cleared for reads
               if (af_push_c) state_q <= we_q ? IDLE : RDATA;
            end
            RDATA: begin
               if (rd_beat_c) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_BEAT) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Requester-side outputs
   assign bus.i_req_ready   = grant_c & ~win_c;
   assign bus.d_req_ready   = grant_c &  win_c;
   assign bus.i_wdata_ready = wdf_push_c & ~owner_q;
   assign bus.d_wdata_ready = wdf_push_c &  owner_q;
   assign bus.i_rdata       = rst ? bus.rdf_dout : '0;
   assign bus.d_rdata       = rst ? bus.rdf_dout : '0;
   assign bus.i_rdata_valid = rd_beat_c & ~owner_q;
   assign bus.d_rdata_valid = rd_beat_c &  owner_q;

   // Controller-side outputs
   assign bus.af_wr_en      = af_push_c;
   assign bus.af_cmd        = rst ? {2'b00, ~we_q} : 3'b000;
   assign bus.af_addr_din   = rst ? addr_q : '0;
   assign bus.wdf_wr_en     = wdf_push_c;
   assign bus.wdf_din       = !rst ? '0 : (owner_q ? bus.d_wdata : bus.i_wdata);
   assign bus.wdf_mask_din  = !rst ? '0 : (owner_q ? bus.d_wmask : bus.i_wmask);

   // Status
   assign bus.busy          = rst & (state_q != IDLE);
   assign bus.owner         = rst & owner_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Self-checking bench for cache_mem_arbiter. A transaction-level model
// (pending requests, expected write beats, outstanding command and read
// beat count) predicts every handshake each cycle; directed steps cover
// reset, a plain read, a stalled write, arbitration, command-FIFO stall
// and reset during a read, followed by randomized traffic.
module tb_cache_mem_arbiter;
   localparam int unsigned ADDR_W = 31;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned MASK_W = DATA_W / 8;
   localparam int unsigned BEATS  = 2;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // requester state (index 0 = icache, 1 = dcache)
   bit                pend_v   [2];
   bit                pend_we  [2];
   logic [ADDR_W-1:0] pend_addr[2];
   logic [DATA_W-1:0] wd[2][BEATS];
   logic [MASK_W-1:0] wm[2][BEATS];
   int                idx[2];

   // transaction model
   bit                act_m, own_m, we_m, cmd_done, last_g;
   logic [ADDR_W-1:0] addr_m;
   int                wleft, rleft;
   logic [DATA_W-1:0] q_wd[$];
   logic [MASK_W-1:0] q_wm[$];
   bit                obs_g[$];
   int                n_af, n_wdf, n_rv;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic void drive_req();
      int b0, b1;
      b0 = (idx[0] < int'(BEATS)) ? idx[0] : int'(BEATS) - 1;
      b1 = (idx[1] < int'(BEATS)) ? idx[1] : int'(BEATS) - 1;
      bus.i_req_valid = pend_v[0];
      bus.i_req_we    = pend_we[0];
      bus.i_req_addr  = pend_addr[0];
      bus.i_wdata     = wd[0][b0];
      bus.i_wmask     = wm[0][b0];
      bus.d_req_valid = pend_v[1];
      bus.d_req_we    = pend_we[1];
      bus.d_req_addr  = pend_addr[1];
      bus.d_wdata     = wd[1][b1];
      bus.d_wmask     = wm[1][b1];
   endfunction

   function automatic void model_reset();
      act_m = 0; cmd_done = 0; wleft = 0; rleft = 0; last_g = 0;
      q_wd.delete(); q_wm.delete();
   endfunction

   task automatic post(input int p, input bit we, input logic [ADDR_W-1:0] addr);
      pend_v[p] = 1; pend_we[p] = we; pend_addr[p] = addr; idx[p] = 0;
      for (int b = 0; b < int'(BEATS); b++) begin
         wd[p][b] = rand_data();
         wm[p][b] = MASK_W'($urandom());
      end
      drive_req();
   endtask

   task automatic quiet();
      bus.wdf_full = 0; bus.af_full = 0; bus.rdf_valid = 0; bus.rdf_dout = rand_data();
   endtask

   task automatic ctl_rand(input bit bp);
      bus.wdf_full  = bp && ($urandom_range(2) == 0);
      bus.af_full   = bp && ($urandom_range(2) == 0);
      bus.rdf_valid = $urandom_range(1) == 1;
      bus.rdf_dout  = rand_data();
   endtask

   // One clock: check outputs mid-cycle against the model, then advance
   task automatic tick();
      bit act0, cd0, any, w, exp_wen, exp_aen, exp_rv;
      int wl0, rl0;
      @(negedge clk);
      if (bus.af_wr_en) n_af++;
      if (bus.wdf_wr_en) n_wdf++;
      if (bus.i_rdata_valid || bus.d_rdata_valid) n_rv++;
      if (!rst) begin
         chk("rst_i_req_ready", bus.i_req_ready, 0);
         chk("rst_d_req_ready", bus.d_req_ready, 0);
         chk("rst_af_wr_en", bus.af_wr_en, 0);
         chk("rst_wdf_wr_en", bus.wdf_wr_en, 0);
         chk("rst_i_rdata_valid", bus.i_rdata_valid, 0);
         chk("rst_d_rdata_valid", bus.d_rdata_valid, 0);
         chk("rst_i_wdata_ready", bus.i_wdata_ready, 0);
         chk("rst_d_wdata_ready", bus.d_wdata_ready, 0);
         chk("rst_busy", bus.busy, 0);
         chk("rst_owner", bus.owner, 0);
         chk("rst_af_cmd", bus.af_cmd, 0);
         chk("rst_i_rdata", bus.i_rdata, 0);
      end else begin
         act0 = act_m; cd0 = cmd_done; wl0 = wleft; rl0 = rleft;
         exp_wen = act0 && we_m && wl0 > 0 && !bus.wdf_full;
         exp_aen = act0 && wl0 == 0 && !cd0 && !bus.af_full;
         exp_rv  = act0 && cd0 && rl0 > 0 && bus.rdf_valid;
         chk("busy", bus.busy, act0);
         if (act0) chk("owner", bus.owner, own_m);
         chk("wdf_wr_en", bus.wdf_wr_en, exp_wen);
         chk("i_wdata_ready", bus.i_wdata_ready, exp_wen && !own_m);
         chk("d_wdata_ready", bus.d_wdata_ready, exp_wen && own_m);
         chk("af_wr_en", bus.af_wr_en, exp_aen);
         chk("i_rdata_valid", bus.i_rdata_valid, exp_rv && !own_m);
         chk("d_rdata_valid", bus.d_rdata_valid, exp_rv && own_m);
         chk("i_rdata", bus.i_rdata, bus.rdf_dout);
         chk("d_rdata", bus.d_rdata, bus.rdf_dout);
         if (exp_wen && bus.wdf_wr_en && q_wd.size() > 0) begin
            chk("wdf_din", bus.wdf_din, q_wd.pop_front());
            chk("wdf_mask_din", bus.wdf_mask_din, q_wm.pop_front());
            idx[own_m]++;
            wleft--;
         end
         if (exp_aen && bus.af_wr_en) begin
            chk("af_cmd", bus.af_cmd, we_m ? 3'b000 : 3'b001);
            chk("af_addr_din", bus.af_addr_din, addr_m);
            if (we_m) act_m = 0;
            else begin
               cmd_done = 1;
               rleft = BEATS;
            end
         end
         if (exp_rv) begin
            rleft--;
            if (rleft == 0) act_m = 0;
         end
         if (!act0) begin
            any = pend_v[0] || pend_v[1];
`ifdef ARB_RR_EN
            w = (pend_v[0] && pend_v[1]) ? !last_g : pend_v[1];
`else
            w = pend_v[1];
`endif
            chk("i_req_ready", bus.i_req_ready, any && !w);
            chk("d_req_ready", bus.d_req_ready, any && w);
            if (any) begin
               obs_g.push_back(bus.d_req_ready);
               own_m = w; we_m = pend_we[w]; addr_m = pend_addr[w];
               wleft = we_m ? BEATS : 0; rleft = 0; cmd_done = 0;
               act_m = 1; last_g = w; pend_v[w] = 0;
               if (we_m) begin
                  for (int b = 0; b < int'(BEATS); b++) begin
                     q_wd.push_back(wd[w][b]);
                     q_wm.push_back(wm[w][b]);
                  end
               end
            end
         end else begin
            chk("i_req_ready_busy", bus.i_req_ready, 0);
            chk("d_req_ready_busy", bus.d_req_ready, 0);
         end
      end
      @(posedge clk);
      if (!rst) model_reset();
      #1;
      drive_req();
   endtask

   task automatic serve(input int budget, input bit bp);
      int n = 0;
      while ((act_m || pend_v[0] || pend_v[1]) && n < budget) begin
         ctl_rand(bp);
         tick();
         n++;
      end
      chk("serve_timeout", act_m || pend_v[0] || pend_v[1], 0);
      if (act_m || pend_v[0] || pend_v[1]) begin
         pend_v[0] = 0; pend_v[1] = 0;
         rst = 0; quiet(); tick(); rst = 1;
      end
      quiet();
   endtask

   initial begin
      int s0, s1, s2, reposts, n, r;
      bit exp_seq[4];
      rst = 0;
      pend_v[0] = 0; pend_v[1] = 0; idx[0] = 0; idx[1] = 0;
      pend_we[0] = 0; pend_we[1] = 0; pend_addr[0] = '0; pend_addr[1] = '0;
      for (int p = 0; p < 2; p++)
         for (int b = 0; b < int'(BEATS); b++) begin
            wd[p][b] = '0; wm[p][b] = '0;
         end
      n_af = 0; n_wdf = 0; n_rv = 0;
      model_reset();
      quiet();
      drive_req();

      // reset held with both requesters valid, then grant on first cycle
      post(0, 0, 31'h0000010);
      post(1, 0, 31'h0000020);
      for (int k = 0; k < 5; k++) tick();
      rst = 1;
      tick();
      chk("first_grant_taken", act_m, 1);
      serve(200, 0);

      // icache read at 0x100, no backpressure
      s0 = n_af; s2 = n_rv;
      post(0, 0, 31'h0000100);
      tick();                                    // cycle 0: grant
      tick();                                    // cycle 1: command push
      chk("rd_af_cycle1", n_af - s0, 1);
      bus.rdf_valid = 1; bus.rdf_dout = {32'hAAAA_AAAA, 96'h0}; tick();
      bus.rdf_dout = {32'hBBBB_BBBB, 96'h0}; tick();
      quiet();
      tick();                                    // idle: busy low
      chk("rd_beats", n_rv - s2, 2);

      // dcache write at 0x40 with wdf_full during cycles 1..3
      s0 = n_af; s1 = n_wdf;
      post(1, 1, 31'h0000040);
      tick();
      bus.wdf_full = 1;
      for (int k = 0; k < 3; k++) tick();
      chk("wr_no_push_full", n_wdf - s1, 0);
      bus.wdf_full = 0;
      tick(); tick(); tick();
      chk("wr_beats", n_wdf - s1, 2);
      chk("wr_one_cmd", n_af - s0, 1);
      tick();
      chk("wr_done", act_m, 0);

      // arbitration: both held valid for 4 rounds, starting from reset
      rst = 0; tick(); rst = 1;
      obs_g.delete();
      post(0, 0, 31'h0001000);
      post(1, 0, 31'h0002000);
      reposts = 0; n = 0;
      while (obs_g.size() < 4 && n < 200) begin
         ctl_rand(0);
         tick();
         for (int p = 0; p < 2; p++)
            if (!pend_v[p] && reposts < 3 && obs_g.size() < 4) begin
               post(p, 0, ADDR_W'($urandom()));
               reposts++;
            end
         n++;
      end
      chk("arb_rounds", obs_g.size() >= 4, 1);
`ifdef ARB_RR_EN
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      for (int k = 0; k < 4; k++)
         if (obs_g.size() > k) chk($sformatf("arb_round%0d", k), obs_g[k], exp_seq[k]);
      serve(300, 0);

      // af_full for 10 cycles while in CMD
      s0 = n_af;
      post(0, 0, 31'h0002000);
      tick();
      bus.af_full = 1;
      for (int k = 0; k < 10; k++) tick();
      chk("af_stall", n_af - s0, 0);
      bus.af_full = 0;
      tick();
      chk("af_one_push", n_af - s0, 1);
      serve(100, 0);

      // reset after the first read beat; late beat must be dropped
      s2 = n_rv;
      post(1, 0, 31'h0000300);
      tick(); tick();
      bus.rdf_valid = 1; tick();
      bus.rdf_valid = 0;
      rst = 0; tick(); rst = 1;
      bus.rdf_valid = 1; tick();
      bus.rdf_valid = 0;
      chk("late_beat_dropped", n_rv - s2, 1);
      post(0, 1, 31'h0000500);
      serve(100, 0);

      // randomized traffic with backpressure
      for (int t = 0; t < 30; t++) begin
         r = $urandom_range(3);
         if (r == 0) begin
            post(0, 1'($urandom()), ADDR_W'($urandom()));
            post(1, 1'($urandom()), ADDR_W'($urandom()));
         end else begin
            post(r & 1, 1'($urandom()), ADDR_W'($urandom()));
         end
         serve(400, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbiter and sequencer that shares the single DDR2 memory-controller command/data FIFO interface between the instruction cache and data cache miss paths inside the Memory150 hierarchy. It grants one cache line transaction at a time, pushes the write-data beats and the address/command into the controller FIFOs, and routes returning read beats to the owning cache. It sits between the icache/dcache refill/writeback logic and the DDR2 controller wrapper, all on the CPU clock.

## Interface
- ADDR_W, 31: width of line address sent to the controller address FIFO.
- DATA_W, 128: width of one FIFO data beat.
- BEATS, 2: data beats per cache line, for both reads and writes; power of two, 2..8.

Ports: `<p>` is `i` for the icache requester and `d` for the dcache requester; each `<p>_` port exists twice.
- clk  in  1  CPU clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- <p>_req_valid  in  1  line transaction pending; held until accepted.
- <p>_req_we  in  1  1 = writeback (line write), 0 = refill (line read).
- <p>_req_addr  in  ADDR_W  line-aligned address.
- <p>_req_ready  out  1  acceptance strobe for the request.
- <p>_wdata  in  DATA_W  current write beat.
- <p>_wmask  in  DATA_W/8  byte mask for current write beat; 1 = masked.
- <p>_wdata_ready  out  1  current write beat consumed this cycle.
- <p>_rdata  out  DATA_W  read beat, equal to rdf_dout for both ports.
- <p>_rdata_valid  out  1  read beat valid for this requester.
- af_cmd  out  3  3'b000 write, 3'b001 read.
- af_addr_din  out  ADDR_W  latched address.
- af_wr_en  out  1  push into address FIFO.
- af_full  in  1  address FIFO full.
- wdf_din  out  DATA_W  write beat to controller.
- wdf_mask_din  out  DATA_W/8  write mask to controller.
- wdf_wr_en  out  1  push into write-data FIFO.
- wdf_full  in  1  write-data FIFO full.
- rdf_dout  in  DATA_W  read beat from controller.
- rdf_valid  in  1  read beat present.
- busy  out  1  state != IDLE.
- owner  out  1  latched winner; 1 = dcache.

## Operation
- FSM states are IDLE, WDATA, CMD, and RDATA. A beat counter of log2(BEATS) bits tracks progress through a line.
- IDLE:
  - If any `<p>_req_valid` is set, select a winner. The winner's `<p>_req_ready` = 1 combinationally in that cycle.
  - Latch owner, we and addr, and clear the beat counter.
  - Next state is WDATA if we = 1, else CMD.
- WDATA:
  - wdf_wr_en = ~wdf_full. wdf_din and wdf_mask_din pass through the owner's wdata and wmask.
  - Owner's wdata_ready = wdf_wr_en.
  - Counter increments on each push. Push of beat BEATS-1 goes to CMD.
- CMD:
  - af_wr_en = ~af_full, with af_cmd set from latched we and af_addr_din = latched addr.
  - On push: a write goes to IDLE, a read goes to RDATA.
- RDATA:
  - Owner's rdata_valid = rdf_valid; the non-owner's rdata_valid is 0.
  - Counter increments per rdf_valid. Beat BEATS-1 goes to IDLE.
- rdf_valid outside RDATA is dropped and never forwarded.
- Writes push all data before the command; the controller requires data present at command time.
- Requester and controller handshake signals are combinational; state, counter and latched fields are registered.

## Timing
- Reset (rst = 0 at posedge): state IDLE, counter 0, owner 0, latched addr/we 0. RR pointer (if compiled) favours dcache.
- While rst = 0, every output is 0, including `<p>_req_ready`.
- Read with no backpressure: accepted cycle 0, af_wr_en cycle 1, rdata_valid tracks rdf_valid exactly with zero added latency. After the last beat, IDLE is entered on the next edge.
- Write with no backpressure: accepted cycle 0, wdf pushes cycles 1..BEATS, af_wr_en cycle BEATS+1.
- Minimum gap is 1 cycle of IDLE between transactions; back-to-back grants come every BEATS+2 cycles for writes.
- Backpressure: wdf_full or af_full stalls only the current state. No push is issued while full, and beat order is preserved.
- Reset mid-transaction abandons the transaction: no further af/wdf pushes, and late read beats are dropped.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. When both requesters are valid in IDLE, the one not granted last wins. The pointer updates on every grant.
- ARB_RR_EN undefined: fixed priority, dcache always wins simultaneous requests. icache can starve while dcache requests back-to-back.

## Test plan
- Reset: hold rst = 0 for 5 cycles with both req_valid = 1 -> all outputs 0, no req_ready, busy = 0. After release, a grant occurs on the first cycle.
- icache read, addr 0x0000100, BEATS = 2:
  - i_req_ready cycle 0; af_wr_en cycle 1 with af_cmd = 001 and af_addr_din = 0x100.
  - rdf beats 0xA.., 0xB.. -> i_rdata_valid on exactly those 2 cycles; d_rdata_valid stays 0. busy drops the cycle after.
- dcache write, addr 0x40, wdf_full high cycles 1–3:
  - wdf_wr_en = 0 while full.
  - Both beats and masks are pushed in order, each with d_wdata_ready.
  - Then af_cmd = 000, addr 0x40, exactly one af_wr_en.
- Simultaneous i/d reads, 4 rounds with both held valid:
  - Fixed priority: dcache always wins.
  - With ARB_RR_EN: grants alternate d, i, d, i.
- af_full high 10 cycles in CMD -> af_wr_en = 0 throughout, then exactly one push on the first cycle with af_full = 0.
- rst = 0 after first read beat in RDATA -> IDLE next edge. A following rdf_valid pulse produces no `<p>_rdata_valid`, and a new request is granted normally.
